// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: memory opcodes, exception codes,
// FSM state type and common constants.
package mem_lsu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_LMIS = 2'd1;
    localparam logic [1:0] EXC_SMIS = 2'd2;
    localparam logic [1:0] EXC_BUS  = 2'd3;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian lane logic: byte enables, store-data replication, load-data
// extraction with sign/zero extension, and alignment checking.
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        i_op,
    input  logic [1:0]        i_off,
    input  logic [DATA_W-1:0] i_sdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [3:0]        o_sel,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_ldata,
    output logic              o_misal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant lane on a big-endian bus.
    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];
    end

    always_comb begin
        o_sel   = SEL_NONE;
        o_wdata = '0;
        o_ldata = '0;
        o_misal = 1'b0;
        case (i_op)
            OP_LB, OP_LBU, OP_SB: begin
                o_sel   = 4'b1000 >> i_off;
                o_wdata = {(DATA_W/8){i_sdata[7:0]}};
                o_ldata = (i_op == OP_LB) ? {{(DATA_W-8){w_byte[7]}}, w_byte}
                                          : {{(DATA_W-8){1'b0}}, w_byte};
            end
            OP_LH, OP_LHU, OP_SH: begin
                o_sel   = i_off[1] ? 4'b0011 : 4'b1100;
                o_misal = i_off[0];
                o_wdata = {(DATA_W/16){i_sdata[15:0]}};
                o_ldata = (i_op == OP_LH) ? {{(DATA_W-16){w_half[15]}}, w_half}
                                          : {{(DATA_W-16){1'b0}}, w_half};
            end
            OP_LW, OP_SW: begin
                o_sel   = SEL_WORD;
                o_misal = (i_off != 2'd0);
                o_wdata = i_sdata;
                o_ldata = i_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage load/store unit: single-outstanding bus access with stall,
// timeout, misalignment and bus-error exceptions.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [3:0]        memop_i,
    input  logic [ADDR_W-1:0] maddr_i,
    input  logic [DATA_W-1:0] sdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stallreq_o,
    output logic              excp_o,
    output logic [1:0]        excp_code_o
);

    localparam int             CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_rdy;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_sel;
    logic [DATA_W-1:0] r_wdata;

    logic              w_mem;
    logic              w_misal;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_swdata;
    logic [DATA_W-1:0] w_ldata;

    assign w_mem = is_load(memop_i) || is_store(memop_i);

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .i_op    (memop_i),
        .i_off   (maddr_i[1:0]),
        .i_sdata (sdata_i),
        .i_rdata (r_rdata),
        .o_sel   (w_sel),
        .o_wdata (w_swdata),
        .o_ldata (w_ldata),
        .o_misal (w_misal)
    );

    // r_rdy holds off the first launch until the second edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_rdy   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_sel   <= SEL_NONE;
            r_wdata <= '0;
        end else begin
            r_rdy <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_mem && !w_misal && r_rdy) begin
                        r_state <= ST_BUSY;
                        r_req   <= 1'b1;
                        r_we    <= is_store(memop_i);
                        r_addr  <= {maddr_i[ADDR_W-1:2], 2'b00};
                        r_sel   <= w_sel;
                        r_wdata <= w_swdata;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack_i) begin
                        r_req   <= 1'b0;
                        r_rdata <= mem_rdata_i;
                        r_err   <= mem_err_i;
                        r_state <= ST_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_sel_o   = r_sel;
    assign mem_wdata_o = r_wdata;

    // Write-back outputs stay combinational so NOPs pass with zero latency.
    always_comb begin
        wd_o        = wd_i;
        wreg_o      = 1'b0;
        wdata_o     = wdata_i;
        stallreq_o  = 1'b0;
        excp_o      = 1'b0;
        excp_code_o = EXC_NONE;
        if (!rst) begin
            wd_o    = '0;
            wdata_o = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_mem) begin
                        wreg_o = wreg_i;
                    end else if (w_misal) begin
                        excp_o      = 1'b1;
                        excp_code_o = is_store(memop_i) ? EXC_SMIS : EXC_LMIS;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                ST_BUSY: stallreq_o = 1'b1;
                ST_DONE: begin
                    wdata_o = w_ldata;
                    if (r_err) begin
                        excp_o      = 1'b1;
                        excp_code_o = EXC_BUS;
                    end else if (is_load(memop_i)) begin
                        wreg_o = wreg_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a short bus timeout.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [3:0]  memop_i;
    logic [31:0] maddr_i;
    logic [31:0] sdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        excp_o;
    logic [1:0]  excp_code_o;

    int n_chk;
    int n_fail;

    logic        cap_req;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_sel;
    logic [31:0] cap_wdata;

    mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .memop_i     (memop_i),
        .maddr_i     (maddr_i),
        .sdata_i     (sdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_sel_o   (mem_sel_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_err_i   (mem_err_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stallreq_o  (stallreq_o),
        .excp_o      (excp_o),
        .excp_code_o (excp_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop;
        memop_i   = OP_NOP;
        maddr_i   = 32'h0;
        sdata_i   = 32'h0;
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
    endtask

    // Launches one access, captures the bus in the first BUSY cycle, raises
    // ack in BUSY cycle ack_cyc and returns sampled in the DONE cycle.
    task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int ack_cyc, input logic err);
        memop_i   = op;
        maddr_i   = addr;
        sdata_i   = sdata;
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
        tick;
        cap_req   = mem_req_o;
        cap_we    = mem_we_o;
        cap_addr  = mem_addr_o;
        cap_sel   = mem_sel_o;
        cap_wdata = mem_wdata_o;
        for (int c = 1; c < ack_cyc; c++) tick;
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
        mem_err_i   = err;
        tick;
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        wd_i = 5'h1F; wreg_i = 1'b1; wdata_i = 32'hA5A5A5A5;
        set_nop();
        mem_rdata_i = 32'h0;
        #1;
        n_chk++; if (wd_o !== 5'h0) begin n_fail++; $display("FAIL rst_wd got=%h exp=0", wd_o); end
        n_chk++; if (wreg_o !== 1'b0) begin n_fail++; $display("FAIL rst_wreg got=%b exp=0", wreg_o); end
        n_chk++; if (wdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got=%h exp=0", wdata_o); end
        n_chk++; if ({mem_req_o, stallreq_o, excp_o} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl got=%b exp=000", {mem_req_o, stallreq_o, excp_o}); end
        tick; tick;
        rst = 1'b1;
        tick; tick;
    endtask

    task automatic test_nop;
        wd_i = 5'h1A; wreg_i = 1'b1; wdata_i = 32'h5555AAAA;
        #1;
        n_chk++; if ({wd_o, wreg_o, wdata_o} !== {5'h1A, 1'b1, 32'h5555AAAA}) begin n_fail++; $display("FAIL nop_pass got=%h/%b/%h exp=1a/1/5555aaaa", wd_o, wreg_o, wdata_o); end
        wd_i = 5'h03; wreg_i = 1'b0; wdata_i = 32'h01234567;
        #1;
        n_chk++; if ({wd_o, wreg_o, wdata_o} !== {5'h03, 1'b0, 32'h01234567}) begin n_fail++; $display("FAIL nop_comb got=%h/%b/%h exp=03/0/01234567", wd_o, wreg_o, wdata_o); end
        n_chk++; if ({stallreq_o, mem_req_o} !== 2'b00) begin n_fail++; $display("FAIL nop_stall got=%b exp=00", {stallreq_o, mem_req_o}); end
        tick;
    endtask

    task automatic test_lw;
        int stalls;
        wd_i = 5'h07; wreg_i = 1'b1; wdata_i = 32'h0;
        memop_i = OP_LW; maddr_i = 32'h100; mem_ack_i = 1'b0;
        #1;
        stalls = 0;
        if (stallreq_o) stalls++;
        n_chk++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL lw_idle_req got=%b exp=0", mem_req_o); end
        tick;
        if (stallreq_o) stalls++;
        n_chk++; if ({mem_req_o, mem_we_o, mem_sel_o, mem_addr_o} !== {1'b1, 1'b0, 4'b1111, 32'h100}) begin n_fail++; $display("FAIL lw_bus got=%b/%b/%b/%h exp=1/0/1111/100", mem_req_o, mem_we_o, mem_sel_o, mem_addr_o); end
        tick;
        if (stallreq_o) stalls++;
        tick;
        if (stallreq_o) stalls++;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        tick;
        mem_ack_i = 1'b0;
        n_chk++; if (stalls !== 4) begin n_fail++; $display("FAIL lw_stall_cycles got=%0d exp=4", stalls); end
        n_chk++; if ({stallreq_o, mem_req_o} !== 2'b00) begin n_fail++; $display("FAIL lw_done_ctl got=%b exp=00", {stallreq_o, mem_req_o}); end
        n_chk++; if ({wd_o, wreg_o, wdata_o} !== {5'h07, 1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL lw_wb got=%h/%b/%h exp=07/1/deadbeef", wd_o, wreg_o, wdata_o); end
        set_nop(); tick;
    endtask

    task automatic test_sub_loads;
        wreg_i = 1'b1;
        run_access(OP_LB, 32'h103, 32'h0, 32'h123456F0, 1, 1'b0);
        n_chk++; if (cap_sel !== 4'b0001) begin n_fail++; $display("FAIL lb_sel got=%b exp=0001", cap_sel); end
        n_chk++; if ({wreg_o, wdata_o} !== {1'b1, 32'hFFFFFFF0}) begin n_fail++; $display("FAIL lb_data got=%b/%h exp=1/fffffff0", wreg_o, wdata_o); end
        set_nop(); tick;
        run_access(OP_LBU, 32'h103, 32'h0, 32'h123456F0, 2, 1'b0);
        n_chk++; if ({wreg_o, wdata_o} !== {1'b1, 32'h000000F0}) begin n_fail++; $display("FAIL lbu_data got=%b/%h exp=1/000000f0", wreg_o, wdata_o); end
        set_nop(); tick;
        run_access(OP_LB, 32'h100, 32'h0, 32'h80123456, 1, 1'b0);
        n_chk++; if ({cap_sel, wdata_o} !== {4'b1000, 32'hFFFFFF80}) begin n_fail++; $display("FAIL lb0_data got=%b/%h exp=1000/ffffff80", cap_sel, wdata_o); end
        set_nop(); tick;
        run_access(OP_LH, 32'h100, 32'h0, 32'hABCD1234, 1, 1'b0);
        n_chk++; if ({cap_sel, wdata_o} !== {4'b1100, 32'hFFFFABCD}) begin n_fail++; $display("FAIL lh_data got=%b/%h exp=1100/ffffabcd", cap_sel, wdata_o); end
        set_nop(); tick;
        run_access(OP_LHU, 32'h102, 32'h0, 32'h1234ABCD, 1, 1'b0);
        n_chk++; if ({cap_sel, wdata_o} !== {4'b0011, 32'h0000ABCD}) begin n_fail++; $display("FAIL lhu_data got=%b/%h exp=0011/0000abcd", cap_sel, wdata_o); end
        set_nop(); tick;
    endtask

    task automatic test_store;
        wreg_i = 1'b1;
        run_access(OP_SH, 32'h202, 32'h0000ABCD, 32'h0, 1, 1'b0);
        n_chk++; if ({cap_req, cap_we, cap_sel, cap_addr} !== {1'b1, 1'b1, 4'b0011, 32'h200}) begin n_fail++; $display("FAIL sh_bus got=%b/%b/%b/%h exp=1/1/0011/200", cap_req, cap_we, cap_sel, cap_addr); end
        n_chk++; if (cap_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got=%h exp=abcdabcd", cap_wdata); end
        n_chk++; if ({wreg_o, excp_o, stallreq_o} !== 3'b000) begin n_fail++; $display("FAIL sh_done got=%b exp=000", {wreg_o, excp_o, stallreq_o}); end
        set_nop(); tick;
        run_access(OP_SB, 32'h201, 32'h123456A5, 32'h0, 1, 1'b0);
        n_chk++; if ({cap_sel, cap_wdata} !== {4'b0100, 32'hA5A5A5A5}) begin n_fail++; $display("FAIL sb_bus got=%b/%h exp=0100/a5a5a5a5", cap_sel, cap_wdata); end
        set_nop(); tick;
        run_access(OP_SW, 32'h204, 32'hCAFEF00D, 32'h0, 1, 1'b0);
        n_chk++; if ({cap_sel, cap_wdata, cap_addr} !== {4'b1111, 32'hCAFEF00D, 32'h204}) begin n_fail++; $display("FAIL sw_bus got=%b/%h/%h exp=1111/cafef00d/204", cap_sel, cap_wdata, cap_addr); end
        set_nop(); tick;
    endtask

    task automatic test_misaligned;
        wreg_i = 1'b1;
        memop_i = OP_LW; maddr_i = 32'h101;
        #1;
        n_chk++; if ({excp_o, excp_code_o} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL mis_lw_excp got=%b/%0d exp=1/1", excp_o, excp_code_o); end
        n_chk++; if ({wreg_o, stallreq_o, mem_req_o} !== 3'b000) begin n_fail++; $display("FAIL mis_lw_ctl got=%b exp=000", {wreg_o, stallreq_o, mem_req_o}); end
        set_nop(); tick;
        n_chk++; if ({excp_o, mem_req_o} !== 2'b00) begin n_fail++; $display("FAIL mis_lw_after got=%b exp=00", {excp_o, mem_req_o}); end
        memop_i = OP_SH; maddr_i = 32'h203;
        #1;
        n_chk++; if ({excp_o, excp_code_o, stallreq_o} !== {1'b1, 2'd2, 1'b0}) begin n_fail++; $display("FAIL mis_sh got=%b/%0d/%b exp=1/2/0", excp_o, excp_code_o, stallreq_o); end
        memop_i = OP_LH; maddr_i = 32'h101;
        #1;
        n_chk++; if ({excp_o, excp_code_o} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL mis_lh got=%b/%0d exp=1/1", excp_o, excp_code_o); end
        set_nop(); tick;
        n_chk++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL mis_no_req got=%b exp=0", mem_req_o); end
    endtask

    task automatic test_timeout;
        int n;
        wreg_i = 1'b1;
        memop_i = OP_LW; maddr_i = 32'h300; mem_ack_i = 1'b0;
        tick;
        n = 0;
        while (mem_req_o && n < 12) begin
            n++;
            tick;
        end
        n_chk++; if (n !== 4) begin n_fail++; $display("FAIL to_req_cycles got=%0d exp=4", n); end
        n_chk++; if ({excp_o, excp_code_o, wreg_o, stallreq_o} !== {1'b1, 2'd3, 1'b0, 1'b0}) begin n_fail++; $display("FAIL to_excp got=%b/%0d/%b/%b exp=1/3/0/0", excp_o, excp_code_o, wreg_o, stallreq_o); end
        set_nop(); tick;
        n_chk++; if (excp_o !== 1'b0) begin n_fail++; $display("FAIL to_pulse got=%b exp=0", excp_o); end
    endtask

    task automatic test_ack_wins;
        wreg_i = 1'b1;
        run_access(OP_LW, 32'h304, 32'h0, 32'h11223344, 4, 1'b0);
        n_chk++; if ({excp_o, wreg_o, wdata_o} !== {1'b0, 1'b1, 32'h11223344}) begin n_fail++; $display("FAIL ackwin got=%b/%b/%h exp=0/1/11223344", excp_o, wreg_o, wdata_o); end
        set_nop(); tick;
        run_access(OP_LW, 32'h308, 32'h0, 32'h55667788, 2, 1'b1);
        n_chk++; if ({excp_o, excp_code_o, wreg_o} !== {1'b1, 2'd3, 1'b0}) begin n_fail++; $display("FAIL buserr got=%b/%0d/%b exp=1/3/0", excp_o, excp_code_o, wreg_o); end
        set_nop(); tick;
    endtask

    task automatic test_ack_ignored;
        wreg_i = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        tick; tick;
        n_chk++; if ({mem_req_o, stallreq_o, excp_o, wreg_o} !== 4'b0001) begin n_fail++; $display("FAIL ack_idle got=%b exp=0001", {mem_req_o, stallreq_o, excp_o, wreg_o}); end
        mem_ack_i = 1'b0;
        tick;
    endtask

    task automatic test_reset_busy;
        wreg_i = 1'b1;
        memop_i = OP_LW; maddr_i = 32'h400; mem_ack_i = 1'b0;
        tick; tick;
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if ({mem_req_o, stallreq_o, wreg_o, excp_o} !== 4'b0000) begin n_fail++; $display("FAIL rstbusy got=%b exp=0000", {mem_req_o, stallreq_o, wreg_o, excp_o}); end
        set_nop();
        tick;
        rst = 1'b1;
        tick; tick;
        n_chk++; if ({mem_req_o, excp_o, wreg_o} !== 3'b001) begin n_fail++; $display("FAIL rstbusy_after got=%b exp=001", {mem_req_o, excp_o, wreg_o}); end
    endtask

    task automatic test_reset_release;
        rst = 1'b0;
        memop_i = OP_LW; maddr_i = 32'h500; mem_ack_i = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        n_chk++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rel_edge1 got=%b exp=0", mem_req_o); end
        tick;
        n_chk++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h500}) begin n_fail++; $display("FAIL rel_edge2 got=%b/%h exp=1/500", mem_req_o, mem_addr_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        tick;
        mem_ack_i = 1'b0;
        n_chk++; if ({wreg_o, wdata_o} !== {1'b1, 32'h0BADF00D}) begin n_fail++; $display("FAIL rel_wb got=%b/%h exp=1/0badf00d", wreg_o, wdata_o); end
        set_nop(); tick;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_nop();
        test_lw();
        test_sub_loads();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_wins();
        test_ack_ignored();
        test_reset_busy();
        test_reset_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
